// File: rtl/exec_dispatch_pkg.sv
// Shared types and constants for the exec_dispatch stage: unit classes,
// opcodes, FSM encoding and the decoded-instruction record.
package exec_dispatch_pkg;

  localparam int CLS_W = 3;
  localparam logic [CLS_W-1:0] CLS_INT = 3'd0;
  localparam logic [CLS_W-1:0] CLS_MUL = 3'd1;
  localparam logic [CLS_W-1:0] CLS_AMO = 3'd2;
  localparam logic [CLS_W-1:0] CLS_FPU = 3'd3;
  localparam logic [CLS_W-1:0] CLS_CMP = 3'd4;

  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_AMO      = 7'b0101111;
  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPC_OP_FP    = 7'b1010011;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [6:0] F7_FCVT_W = 7'b1100000;
  localparam logic [6:0] F7_FMV_X  = 7'b1110000;
  localparam logic [6:0] F7_FCMP   = 7'b1010000;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_WB} state_e;

  typedef struct packed {
    logic [CLS_W-1:0] cls;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             writes_rd;
    logic             illegal;
  } dec_t;

  // RVC 3-bit register fields address x8..x15.
  function automatic logic [4:0] creg(input logic [2:0] r);
    return {2'b01, r};
  endfunction

endpackage

// File: rtl/exec_dispatch_if.sv
// Decode-side, register-file and execution-unit signals of the dispatch stage.
// slave = the dispatch stage itself, master = its environment.
interface exec_dispatch_if #(
  parameter int XLEN      = 32,
  parameter int NUM_UNITS = 5
);
  logic                      iIR_VALID;
  logic                      oIR_READY;
  logic [31:0]               iIR;
  logic [4:0]                oRS1;
  logic [4:0]                oRS2;
  logic [XLEN-1:0]           iRS1_DATA;
  logic [XLEN-1:0]           iRS2_DATA;
  logic [NUM_UNITS-1:0]      oUNIT_VALID;
  logic [NUM_UNITS-1:0]      iUNIT_READY;
  logic [XLEN-1:0]           oUNIT_IN1;
  logic [XLEN-1:0]           oUNIT_IN2;
  logic [31:0]               oUNIT_IR;
  logic [NUM_UNITS-1:0]      iUNIT_DONE;
  logic [NUM_UNITS*XLEN-1:0] iUNIT_OUT;
  logic                      oWB_VALID;
  logic [4:0]                oWB_RD;
  logic [XLEN-1:0]           oWB_DATA;
  logic                      oILLEGAL;
  logic                      oTIMEOUT;

  modport slave (
    input  iIR_VALID, iIR, iRS1_DATA, iRS2_DATA, iUNIT_READY, iUNIT_DONE, iUNIT_OUT,
    output oIR_READY, oRS1, oRS2, oUNIT_VALID, oUNIT_IN1, oUNIT_IN2, oUNIT_IR,
           oWB_VALID, oWB_RD, oWB_DATA, oILLEGAL, oTIMEOUT
  );

  modport master (
    output iIR_VALID, iIR, iRS1_DATA, iRS2_DATA, iUNIT_READY, iUNIT_DONE, iUNIT_OUT,
    input  oIR_READY, oRS1, oRS2, oUNIT_VALID, oUNIT_IN1, oUNIT_IN2, oUNIT_IR,
           oWB_VALID, oWB_RD, oWB_DATA, oILLEGAL, oTIMEOUT
  );
endinterface

// File: rtl/exec_dispatch_decode.sv
// Combinational instruction classifier: unit class, register fields with
// absent fields forced to zero, integer-writeback flag and illegal flag.
module instr_class_decode
  import exec_dispatch_pkg::*;
(
  input  logic [31:0] ir_i,
  output dec_t        dec_o
);
  logic [6:0] opc;
  logic [6:0] f7;
  logic [4:0] r_full, r_s2, r_phi, r_plo;

  assign opc    = ir_i[6:0];
  assign f7     = ir_i[31:25];
  assign r_full = ir_i[11:7];
  assign r_s2   = ir_i[6:2];
  assign r_phi  = creg(ir_i[9:7]);
  assign r_plo  = creg(ir_i[4:2]);

  always_comb begin
    // NOTE: every field gets a default before the case, so no path leaves a latch.
    dec_o = '0;
    if (ir_i[1:0] == 2'b11) begin
      dec_o.cls       = CLS_INT;
      dec_o.rd        = ir_i[11:7];
      dec_o.rs1       = ir_i[19:15];
      dec_o.rs2       = ir_i[24:20];
      dec_o.writes_rd = 1'b1;
      case (opc)
        OPC_OP:                     if (f7 == F7_MULDIV) dec_o.cls = CLS_MUL;
        OPC_OP_IMM, OPC_LOAD, OPC_JALR: dec_o.rs2 = '0;
        OPC_STORE, OPC_BRANCH: begin
          dec_o.rd        = '0;
          dec_o.writes_rd = 1'b0;
        end
        OPC_LUI, OPC_AUIPC, OPC_JAL: begin
          dec_o.rs1 = '0;
          dec_o.rs2 = '0;
        end
        OPC_AMO:                    dec_o.cls = CLS_AMO;
        OPC_LOAD_FP: begin
          dec_o.cls       = CLS_FPU;
          dec_o.rs2       = '0;
          dec_o.writes_rd = 1'b0;
        end
        OPC_STORE_FP: begin
          dec_o.cls       = CLS_FPU;
          dec_o.rd        = '0;
          dec_o.rs2       = '0;
          dec_o.writes_rd = 1'b0;
        end
        OPC_OP_FP: begin
          dec_o.cls       = CLS_FPU;
          dec_o.writes_rd = (f7 == F7_FCVT_W) || (f7 == F7_FMV_X) || (f7 == F7_FCMP);
        end
        default: begin
          dec_o         = '0;
          dec_o.illegal = 1'b1;
        end
      endcase
    end else if (ir_i[15:0] == 16'h0000) begin
      dec_o.illegal = 1'b1;
    end else begin
      dec_o.cls = CLS_CMP;
      // Quadrant and funct3 select the compressed format.
      case ({ir_i[1:0], ir_i[15:13]})
        5'b00_000: begin dec_o.rd = r_plo; dec_o.rs1 = 5'd2; dec_o.writes_rd = 1'b1; end
        5'b00_010: begin dec_o.rd = r_plo; dec_o.rs1 = r_phi; dec_o.writes_rd = 1'b1; end
        5'b00_001, 5'b00_011: dec_o.rs1 = r_phi;
        5'b00_101, 5'b00_110, 5'b00_111: begin dec_o.rs1 = r_phi; dec_o.rs2 = r_plo; end
        5'b01_000, 5'b10_000: begin
          dec_o.rd = r_full; dec_o.rs1 = r_full; dec_o.writes_rd = 1'b1;
        end
        5'b01_001: begin dec_o.rd = 5'd1; dec_o.writes_rd = 1'b1; end
        5'b01_010: begin dec_o.rd = r_full; dec_o.writes_rd = 1'b1; end
        5'b01_011: begin
          dec_o.rd = r_full; dec_o.writes_rd = 1'b1;
          if (r_full == 5'd2) dec_o.rs1 = 5'd2;
        end
        5'b01_100: begin
          dec_o.rd = r_phi; dec_o.rs1 = r_phi; dec_o.writes_rd = 1'b1;
          if (ir_i[11:10] == 2'b11) dec_o.rs2 = r_plo;
        end
        5'b01_110, 5'b01_111: dec_o.rs1 = r_phi;
        5'b10_010: begin dec_o.rd = r_full; dec_o.rs1 = 5'd2; dec_o.writes_rd = 1'b1; end
        5'b10_001, 5'b10_011: dec_o.rs1 = 5'd2;
        5'b10_100: begin
          if (r_s2 == 5'd0) begin
            dec_o.rs1 = r_full;
            if (ir_i[12] && r_full != 5'd0) begin dec_o.rd = 5'd1; dec_o.writes_rd = 1'b1; end
          end else begin
            dec_o.rd = r_full; dec_o.rs2 = r_s2; dec_o.writes_rd = 1'b1;
            if (ir_i[12]) dec_o.rs1 = r_full;
          end
        end
        5'b10_101, 5'b10_110, 5'b10_111: begin dec_o.rs1 = 5'd2; dec_o.rs2 = r_s2; end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/exec_dispatch.sv
// Registered dispatch stage: accepts one instruction, issues it to its class
// unit, waits for completion or timeout, and emits a one-cycle writeback.
module exec_dispatch
  import exec_dispatch_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NUM_UNITS = 5,
  parameter int TIMEOUT   = 64
) (
  input  logic iCLK,
  input  logic iRST_N,
  exec_dispatch_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [NUM_UNITS-1:0] UNIT_ONE = NUM_UNITS'(1);

  state_e               state_q;
  logic                 ready_q, wr_q, wb_valid_q, illegal_q, timeout_q;
  logic [31:0]          ir_q;
  logic [XLEN-1:0]      in1_q, in2_q, wb_data_q;
  logic [4:0]           rd_q, wb_rd_q;
  logic [NUM_UNITS-1:0] sel_q, unit_valid_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  dec_t                 dec;
  logic                 dec_bad, ir_fire, unit_ready, unit_done, wait_expire, to_idle;
  logic [NUM_UNITS-1:0] dec_sel;
  logic [XLEN-1:0]      unit_result;

  instr_class_decode u_decode (
    .ir_i  (bus.iIR),
    .dec_o (dec)
  );

  assign bus.oRS1 = dec.rs1;
  assign bus.oRS2 = dec.rs2;

  assign dec_bad     = dec.illegal || (int'(dec.cls) >= NUM_UNITS);
  assign dec_sel     = UNIT_ONE << dec.cls;
  assign ir_fire     = ready_q && bus.iIR_VALID;
  assign unit_ready  = |(bus.iUNIT_READY & sel_q);
  assign unit_done   = |(bus.iUNIT_DONE & sel_q);
  assign cnt_d       = cnt_q + CNT_W'(1);
  assign wait_expire = (state_q == ST_WAIT) && !unit_done && (cnt_d == CNT_W'(TIMEOUT));
  assign to_idle     = (state_q == ST_WB) || wait_expire;

  always_comb begin
    unit_result = '0;
    for (int k = 0; k < NUM_UNITS; k++)
      if (sel_q[k]) unit_result = unit_result | bus.iUNIT_OUT[k*XLEN +: XLEN];
  end

  // NOTE: sequential state uses non-blocking assignments only, so later
  // statements in this block see the pre-edge values of every register.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b0;
      ir_q         <= '0;
      in1_q        <= '0;
      in2_q        <= '0;
      rd_q         <= '0;
      wr_q         <= 1'b0;
      sel_q        <= '0;
      unit_valid_q <= '0;
      cnt_q        <= '0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      illegal_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      // Writeback and pulse outputs live for exactly one cycle.
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      illegal_q  <= 1'b0;
      timeout_q  <= wait_expire;
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (ir_fire && dec_bad) begin
            illegal_q <= 1'b1;
          end else if (ir_fire) begin
            state_q      <= ST_ISSUE;
            ready_q      <= 1'b0;
            ir_q         <= bus.iIR;
            in1_q        <= bus.iRS1_DATA;
            in2_q        <= bus.iRS2_DATA;
            rd_q         <= dec.rd;
            wr_q         <= dec.writes_rd;
            sel_q        <= dec_sel;
            unit_valid_q <= dec_sel;
          end
        end
        ST_ISSUE: begin
          if (unit_ready) begin
            unit_valid_q <= '0;
            state_q      <= unit_done ? ST_WB : ST_WAIT;
            if (unit_done) begin
              wb_valid_q <= wr_q && (rd_q != 5'd0);
              wb_rd_q    <= rd_q;
              wb_data_q  <= unit_result;
            end
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_d;
          if (unit_done) begin
            state_q    <= ST_WB;
            wb_valid_q <= wr_q && (rd_q != 5'd0);
            wb_rd_q    <= rd_q;
            wb_data_q  <= unit_result;
          end
        end
        default: ;
      endcase
      if (to_idle) begin
        state_q <= ST_IDLE;
        ready_q <= 1'b1;
        ir_q    <= '0;
        in1_q   <= '0;
        in2_q   <= '0;
        rd_q    <= '0;
        wr_q    <= 1'b0;
        sel_q   <= '0;
        cnt_q   <= '0;
      end
    end
  end

  assign bus.oIR_READY   = ready_q;
  assign bus.oUNIT_VALID = unit_valid_q;
  assign bus.oUNIT_IN1   = in1_q;
  assign bus.oUNIT_IN2   = in2_q;
  assign bus.oUNIT_IR    = ir_q;
  assign bus.oWB_VALID   = wb_valid_q;
  assign bus.oWB_RD      = wb_rd_q;
  assign bus.oWB_DATA    = wb_data_q;
  assign bus.oILLEGAL    = illegal_q;
  assign bus.oTIMEOUT    = timeout_q;
endmodule

// File: tb/tb_exec_dispatch.sv
// Directed bench for exec_dispatch: inputs change and outputs are sampled on
// the falling clock edge; expected values are hand-derived per instruction.
module tb_exec_dispatch;
  localparam int XLEN = 32;
  localparam int NU   = 5;
  localparam int TO   = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  exec_dispatch_if #(.XLEN(XLEN), .NUM_UNITS(NU)) bus ();

  exec_dispatch #(.XLEN(XLEN), .NUM_UNITS(NU), .TIMEOUT(TO)) dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.iIR_VALID   = 1'b0;
    bus.iIR         = '0;
    bus.iRS1_DATA   = '0;
    bus.iRS2_DATA   = '0;
    bus.iUNIT_READY = '0;
    bus.iUNIT_DONE  = '0;
    bus.iUNIT_OUT   = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    checks++; if (bus.oIR_READY !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.oIR_READY); end
    checks++; if ({bus.oUNIT_VALID, bus.oWB_VALID, bus.oILLEGAL, bus.oTIMEOUT} !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %h want 00", {bus.oUNIT_VALID, bus.oWB_VALID, bus.oILLEGAL, bus.oTIMEOUT}); end
    checks++; if ({bus.oUNIT_IN1, bus.oUNIT_IN2, bus.oUNIT_IR, bus.oWB_DATA} !== 128'h0) begin errors++; $display("FAIL reset_data: got %h want 0", {bus.oUNIT_IN1, bus.oUNIT_IN2, bus.oUNIT_IR, bus.oWB_DATA}); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.oIR_READY !== 1'b0) begin errors++; $display("FAIL release_ready_early: got %b want 0", bus.oIR_READY); end
    @(negedge clk);
    checks++; if (bus.oIR_READY !== 1'b1) begin errors++; $display("FAIL release_ready_first_edge: got %b want 1", bus.oIR_READY); end
  endtask

  // ADD x3,x1,x2 on unit 0, ready and done in the first issue cycle.
  task automatic test_add_single_cycle();
    bus.iIR = 32'h002081B3; bus.iIR_VALID = 1'b1; bus.iRS1_DATA = 32'd5; bus.iRS2_DATA = 32'd7;
    #1;
    checks++; if ({bus.oRS1, bus.oRS2} !== {5'd1, 5'd2}) begin errors++; $display("FAIL add_rs: got %0d,%0d want 1,2", bus.oRS1, bus.oRS2); end
    @(negedge clk);
    idle_inputs();
    checks++; if (bus.oIR_READY !== 1'b0) begin errors++; $display("FAIL add_ready_busy: got %b want 0", bus.oIR_READY); end
    checks++; if (bus.oUNIT_VALID !== 5'b00001) begin errors++; $display("FAIL add_unit_valid: got %b want 00001", bus.oUNIT_VALID); end
    checks++; if ({bus.oUNIT_IN1, bus.oUNIT_IN2} !== {32'd5, 32'd7}) begin errors++; $display("FAIL add_operands: got %0d,%0d want 5,7", bus.oUNIT_IN1, bus.oUNIT_IN2); end
    checks++; if (bus.oUNIT_IR !== 32'h002081B3) begin errors++; $display("FAIL add_unit_ir: got %h want 002081b3", bus.oUNIT_IR); end
    bus.iUNIT_READY = 5'b00001; bus.iUNIT_DONE = 5'b00001; bus.iUNIT_OUT[0 +: XLEN] = 32'd12;
    @(negedge clk);
    idle_inputs();
    checks++; if (bus.oWB_VALID !== 1'b1) begin errors++; $display("FAIL add_wb_valid: got %b want 1", bus.oWB_VALID); end
    checks++; if ({bus.oWB_RD, bus.oWB_DATA} !== {5'd3, 32'd12}) begin errors++; $display("FAIL add_wb: got rd %0d data %0d want rd 3 data 12", bus.oWB_RD, bus.oWB_DATA); end
    checks++; if (bus.oUNIT_VALID !== 5'b00000) begin errors++; $display("FAIL add_unit_valid_drop: got %b want 00000", bus.oUNIT_VALID); end
    @(negedge clk);
    checks++; if ({bus.oWB_VALID, bus.oIR_READY} !== 2'b01) begin errors++; $display("FAIL add_back_idle: got wb %b ready %b want 0 1", bus.oWB_VALID, bus.oIR_READY); end
    checks++; if (bus.oUNIT_IN1 !== 32'd0) begin errors++; $display("FAIL add_operand_clear: got %0d want 0", bus.oUNIT_IN1); end
  endtask

  // MUL x5,x6,x7 on unit 1: ready after 2 cycles, done 4 cycles later.
  task automatic test_mul_wait();
    bus.iIR = 32'h027302B3; bus.iIR_VALID = 1'b1; bus.iRS1_DATA = 32'd6; bus.iRS2_DATA = 32'd7;
    #1;
    checks++; if ({bus.oRS1, bus.oRS2} !== {5'd6, 5'd7}) begin errors++; $display("FAIL mul_rs: got %0d,%0d want 6,7", bus.oRS1, bus.oRS2); end
    @(negedge clk);
    idle_inputs();
    checks++; if (bus.oUNIT_VALID !== 5'b00010) begin errors++; $display("FAIL mul_unit_valid_c1: got %b want 00010", bus.oUNIT_VALID); end
    @(negedge clk);
    checks++; if (bus.oUNIT_VALID !== 5'b00010) begin errors++; $display("FAIL mul_unit_valid_held: got %b want 00010", bus.oUNIT_VALID); end
    bus.iUNIT_READY = 5'b00010;
    @(negedge clk);
    bus.iUNIT_READY = '0;
    checks++; if (bus.oUNIT_VALID !== 5'b00000) begin errors++; $display("FAIL mul_unit_valid_after_ready: got %b want 00000", bus.oUNIT_VALID); end
    @(negedge clk);
    bus.iUNIT_DONE = 5'b00001; bus.iUNIT_OUT[0 +: XLEN] = 32'hDEAD;
    @(negedge clk);
    bus.iUNIT_DONE = '0; bus.iUNIT_OUT = '0;
    checks++; if ({bus.oWB_VALID, bus.oIR_READY} !== 2'b00) begin errors++; $display("FAIL mul_stray_done: got wb %b ready %b want 0 0", bus.oWB_VALID, bus.oIR_READY); end
    @(negedge clk);
    bus.iUNIT_DONE = 5'b00010; bus.iUNIT_OUT[1*XLEN +: XLEN] = 32'h2A;
    @(negedge clk);
    idle_inputs();
    checks++; if ({bus.oWB_VALID, bus.oWB_RD, bus.oWB_DATA} !== {1'b1, 5'd5, 32'h2A}) begin errors++; $display("FAIL mul_wb: got v %b rd %0d data %h want 1 5 0000002a", bus.oWB_VALID, bus.oWB_RD, bus.oWB_DATA); end
    @(negedge clk);
    checks++; if ({bus.oWB_VALID, bus.oIR_READY} !== 2'b01) begin errors++; $display("FAIL mul_back_idle: got wb %b ready %b want 0 1", bus.oWB_VALID, bus.oIR_READY); end
  endtask

  // SW x2,0(x1): no destination, so no register write.
  task automatic test_store_no_wb();
    bus.iIR = 32'h0020A023; bus.iIR_VALID = 1'b1; bus.iRS1_DATA = 32'h100; bus.iRS2_DATA = 32'h55;
    #1;
    checks++; if ({bus.oRS1, bus.oRS2} !== {5'd1, 5'd2}) begin errors++; $display("FAIL sw_rs: got %0d,%0d want 1,2", bus.oRS1, bus.oRS2); end
    @(negedge clk);
    idle_inputs();
    bus.iUNIT_READY = 5'b00001; bus.iUNIT_DONE = 5'b00001; bus.iUNIT_OUT[0 +: XLEN] = 32'h104;
    @(negedge clk);
    idle_inputs();
    checks++; if (bus.oWB_VALID !== 1'b0) begin errors++; $display("FAIL sw_wb_valid: got %b want 0", bus.oWB_VALID); end
    @(negedge clk);
    checks++; if ({bus.oWB_VALID, bus.oIR_READY} !== 2'b01) begin errors++; $display("FAIL sw_back_idle: got wb %b ready %b want 0 1", bus.oWB_VALID, bus.oIR_READY); end
  endtask

  // All-zero RVC word, then a custom-0 opcode: both rejected in IDLE.
  task automatic test_illegal();
    bus.iIR = 32'h00000000; bus.iIR_VALID = 1'b1;
    @(negedge clk);
    checks++; if ({bus.oILLEGAL, bus.oUNIT_VALID, bus.oIR_READY} !== {1'b1, 5'b00000, 1'b1}) begin errors++; $display("FAIL illegal_zero: got ill %b uv %b ready %b want 1 00000 1", bus.oILLEGAL, bus.oUNIT_VALID, bus.oIR_READY); end
    bus.iIR = 32'h0000000B;
    @(negedge clk);
    idle_inputs();
    checks++; if ({bus.oILLEGAL, bus.oUNIT_VALID, bus.oIR_READY} !== {1'b1, 5'b00000, 1'b1}) begin errors++; $display("FAIL illegal_custom0: got ill %b uv %b ready %b want 1 00000 1", bus.oILLEGAL, bus.oUNIT_VALID, bus.oIR_READY); end
    @(negedge clk);
    checks++; if ({bus.oILLEGAL, bus.oUNIT_VALID} !== 6'b0) begin errors++; $display("FAIL illegal_pulse_end: got ill %b uv %b want 0 00000", bus.oILLEGAL, bus.oUNIT_VALID); end
  endtask

  // FADD.S f1,f2,f3 on unit 3 whose DONE never comes.
  task automatic test_timeout();
    bus.iIR = 32'h003100D3; bus.iIR_VALID = 1'b1;
    @(negedge clk);
    idle_inputs();
    checks++; if (bus.oUNIT_VALID !== 5'b01000) begin errors++; $display("FAIL fpu_unit_valid: got %b want 01000", bus.oUNIT_VALID); end
    bus.iUNIT_READY = 5'b01000;
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      bus.iUNIT_READY = '0;
      bus.iUNIT_DONE  = (c == 3) ? 5'b00100 : 5'b00000;
      checks++; if ({bus.oTIMEOUT, bus.oIR_READY} !== 2'b00) begin errors++; $display("FAIL fpu_wait_c%0d: got to %b ready %b want 0 0", c, bus.oTIMEOUT, bus.oIR_READY); end
    end
    @(negedge clk);
    bus.iUNIT_DONE = '0;
    checks++; if ({bus.oTIMEOUT, bus.oWB_VALID, bus.oIR_READY} !== 3'b101) begin errors++; $display("FAIL fpu_timeout: got to %b wb %b ready %b want 1 0 1", bus.oTIMEOUT, bus.oWB_VALID, bus.oIR_READY); end
    @(negedge clk);
    checks++; if ({bus.oTIMEOUT, bus.oWB_VALID} !== 2'b00) begin errors++; $display("FAIL fpu_timeout_pulse_end: got to %b wb %b want 0 0", bus.oTIMEOUT, bus.oWB_VALID); end
  endtask

  // Reset during a MUL wait, then C.ADDI x10,1 via the compressed unit.
  task automatic test_reset_mid_wait();
    bus.iIR = 32'h027302B3; bus.iIR_VALID = 1'b1; bus.iRS1_DATA = 32'd9; bus.iRS2_DATA = 32'd3;
    @(negedge clk);
    idle_inputs();
    bus.iUNIT_READY = 5'b00010;
    @(negedge clk);
    bus.iUNIT_READY = '0;
    checks++; if (bus.oUNIT_IN1 !== 32'd9) begin errors++; $display("FAIL rst_pre_operand: got %0d want 9", bus.oUNIT_IN1); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus.oIR_READY, bus.oUNIT_VALID, bus.oWB_VALID, bus.oWB_RD, bus.oILLEGAL, bus.oTIMEOUT} !== 14'h0) begin errors++; $display("FAIL rst_async_ctrl: got %h want 0", {bus.oIR_READY, bus.oUNIT_VALID, bus.oWB_VALID, bus.oWB_RD, bus.oILLEGAL, bus.oTIMEOUT}); end
    checks++; if ({bus.oUNIT_IN1, bus.oUNIT_IN2, bus.oUNIT_IR, bus.oWB_DATA} !== 128'h0) begin errors++; $display("FAIL rst_async_data: got %h want 0", {bus.oUNIT_IN1, bus.oUNIT_IN2, bus.oUNIT_IR, bus.oWB_DATA}); end
    bus.iUNIT_DONE = 5'b00010; bus.iUNIT_OUT[1*XLEN +: XLEN] = 32'd27;
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({bus.oIR_READY, bus.oWB_VALID} !== 2'b10) begin errors++; $display("FAIL rst_release: got ready %b wb %b want 1 0", bus.oIR_READY, bus.oWB_VALID); end
    bus.iIR = 32'h00000505; bus.iIR_VALID = 1'b1; bus.iRS1_DATA = 32'd41;
    #1;
    checks++; if ({bus.oRS1, bus.oRS2} !== {5'd10, 5'd0}) begin errors++; $display("FAIL caddi_rs: got %0d,%0d want 10,0", bus.oRS1, bus.oRS2); end
    @(negedge clk);
    idle_inputs();
    checks++; if ({bus.oUNIT_VALID, bus.oUNIT_IN1} !== {5'b10000, 32'd41}) begin errors++; $display("FAIL caddi_issue: got uv %b in1 %0d want 10000 41", bus.oUNIT_VALID, bus.oUNIT_IN1); end
    bus.iUNIT_READY = 5'b10000; bus.iUNIT_DONE = 5'b10000; bus.iUNIT_OUT[4*XLEN +: XLEN] = 32'd42;
    @(negedge clk);
    idle_inputs();
    checks++; if ({bus.oWB_VALID, bus.oWB_RD, bus.oWB_DATA} !== {1'b1, 5'd10, 32'd42}) begin errors++; $display("FAIL caddi_wb: got v %b rd %0d data %0d want 1 10 42", bus.oWB_VALID, bus.oWB_RD, bus.oWB_DATA); end
    @(negedge clk);
    checks++; if ({bus.oWB_VALID, bus.oIR_READY} !== 2'b01) begin errors++; $display("FAIL caddi_back_idle: got wb %b ready %b want 0 1", bus.oWB_VALID, bus.oIR_READY); end
  endtask

  initial begin
    test_reset();
    test_add_single_cycle();
    test_mul_wait();
    test_store_no_wb();
    test_illegal();
    test_timeout();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule

// File: doc/exec_dispatch.md
# exec_dispatch

Registered instruction dispatch stage between decode and a parametrised set of execution units. It accepts one 32-bit or 16-bit (RVC) instruction per transaction over a valid/ready handshake and classifies it into an execution-unit class. It latches register operands, issues to exactly one unit with a per-unit handshake, waits for that unit's completion (with a timeout), and emits a single-cycle writeback.

## Interface
- XLEN, 32, operand/result width
- NUM_UNITS, 5, execution units attached; class index ≥ NUM_UNITS is illegal
- TIMEOUT, 64, max cycles in WAIT before abort (≥ 2)
- iCLK  in  1  clock
- iRST_N  in  1  reset; one clock, reset asynchronous active-low
- iIR_VALID  in  1  instruction offered
- oIR_READY  out  1  stage can accept
- iIR  in  32  instruction; RVC when iIR[1:0] != 2'b11 (only [15:0] used)
- oRS1, oRS2  out  5  register-file read addresses, combinational from iIR
- iRS1_DATA, iRS2_DATA  in  XLEN  register-file read data, same cycle
- oUNIT_VALID  out  NUM_UNITS  one-hot issue request
- iUNIT_READY  in  NUM_UNITS  per-unit accept
- oUNIT_IN1, oUNIT_IN2  out  XLEN  latched operands, shared bus
- oUNIT_IR  out  32  latched instruction, shared bus
- iUNIT_DONE  in  NUM_UNITS  per-unit completion pulse
- iUNIT_OUT  in  NUM_UNITS*XLEN  per-unit result, unit k at [k*XLEN +: XLEN]
- oWB_VALID  out  1  register write enable, one cycle
- oWB_RD  out  5  destination
- oWB_DATA  out  XLEN  result
- oILLEGAL  out  1  one-cycle illegal-instruction pulse
- oTIMEOUT  out  1  one-cycle unit-timeout pulse

## Operation
- Classes: 0 INT (opcodes 0010011, 0000011, 1100111, 0100011, 1100011, 0110111, 0010111, 1101111, and 0110011 with funct7 != 0000001); 1 MUL (0110011, funct7 == 0000001); 2 AMO (0101111); 3 FPU (0000111, 0100111, 1010011); 4 CMP (any RVC). Any other opcode, or RVC 16'h0000, is illegal.
- Field extraction for 32-bit instructions: rd = [11:7], rs1 = [19:15], rs2 = [24:20].
- Absent fields are forced to 0: S/B have no rd; U/J have no rs1/rs2; 0000111/0100111 have no rs2; I-type has no rs2.
- FPU writes an integer rd only when funct7 ∈ {1100000, 1110000, 1010000}.
- RVC fields follow CR/CI/CSS/CIW/CL/CS/CB/CJ; 3-bit prime registers map to x8–x15.
- FSM states:
  - IDLE: oIR_READY=1. On iIR_VALID, latch iIR, operands, rd, class → ISSUE. If illegal, pulse oILLEGAL instead and stay IDLE.
  - ISSUE: oUNIT_VALID[class]=1 held until iUNIT_READY[class]. Same-cycle iUNIT_DONE[class] → WB; otherwise → WAIT.
  - WAIT: counter increments each cycle. iUNIT_DONE[class] → capture iUNIT_OUT slice, go WB. Counter reaching TIMEOUT → pulse oTIMEOUT, go IDLE, no writeback.
  - WB: oWB_VALID=1 only if the instruction writes rd and rd != 0. oWB_RD/oWB_DATA are valid this cycle. → IDLE.
- DONE from non-selected units is ignored in every state. DONE in IDLE is ignored.
- Operand registers and the counter clear on entry to IDLE.

## Timing
- Reset values (async, while iRST_N low): state IDLE; oIR_READY=0. All of oUNIT_VALID, oUNIT_IN1/2, oUNIT_IR, oWB_*, oILLEGAL, oTIMEOUT, and the counter are 0.
- oIR_READY rises at the first iCLK edge after reset release.
- All outputs except oRS1/oRS2 are registered.
- Latency, accept edge at cycle 0:
  - single-cycle unit (ready and done in cycle 1): oWB_VALID in cycle 2;
  - otherwise: oWB_VALID one cycle after the DONE cycle.
- Throughput: at most one instruction per 3 cycles. oIR_READY=0 outside IDLE.
- Reset asserted mid-transaction aborts immediately; no writeback or pulse follows.

## Structure
- Shared package exec_dispatch_pkg holds:
  - class localparams (CLS_INT..CLS_CMP, CLS_W=3);
  - opcode constants;
  - FPU int-destination funct7 constants;
  - state encoding (IDLE/ISSUE/WAIT/WB).
- Sub-module instr_class_decode is combinational: iIR → class, rd, rs1, rs2, writes_rd, illegal. It also drives oRS1/oRS2.
- FSM, counter, latches and result mux live in exec_dispatch.

## Test plan
- ADD x3,x1,x2 (0x002081B3), x1=5, x2=7; unit 0 ready and done in cycle 1 returning 12 → oWB_VALID cycle 2, rd=3, data 12.
- MUL x5,x6,x7 (0x027302B3); unit 1 ready after 2 cycles, done 4 cycles later returning 0x2A → oUNIT_VALID=00010 until ready; WB rd=5, data 0x2A; stray iUNIT_DONE[0] during WAIT ignored.
- SW x2,0(x1) (0x0020A023), unit 0 completes → oWB_VALID stays 0 through WB; oRS2=2.
- Instruction 0x00000000, then opcode 0001011 → oILLEGAL one cycle each; oUNIT_VALID stays 0; oIR_READY stays 1.
- NUM_UNITS=5, TIMEOUT=8: FPU op issued, iUNIT_DONE never asserted → oTIMEOUT pulses exactly 8 WAIT cycles after entering WAIT; no WB; back in IDLE.
- iRST_N dropped during WAIT of a MUL → all outputs 0 asynchronously; after release, oIR_READY=1 at the first edge; the subsequent C.ADDI (0x0505, x10 += 1) writes rd=10 via unit 4.
